// File: rtl/scaler_v_ctrl.sv
// Per-frame vertical sequencer: primes the line matrix, steps the vertical LUT, issues fetch/emit handshakes.
// Optional ack watchdog with timeout_err port: define SCALER_V_CTRL_TIMEOUT_EN.
module scaler_v_ctrl #(
  parameter int unsigned IMG_V_MAX      = 1080,
  parameter int unsigned IMG_V_BITWIDTH = 11,
  parameter int unsigned KERNEL_MAX     = 4,
  parameter int unsigned LUT_LATENCY    = 2
`ifdef SCALER_V_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                      core_clk,
  input  logic                      core_rst_n,
  input  logic [IMG_V_BITWIDTH-1:0] core_arg_img_src_v,
  input  logic [IMG_V_BITWIDTH-1:0] core_arg_img_des_v,
  input  logic                      frame_start,
  output logic                      lut_rst,
  output logic                      v_start,
  input  logic                      matrix_ram_read_stride,
  input  logic                      matrix_ram_read_repeat,
  output logic                      fetch_req,
  input  logic                      fetch_ack,
  output logic                      emit_req,
  input  logic                      emit_ack,
  output logic                      busy,
  output logic                      frame_done,
  output logic [IMG_V_BITWIDTH-1:0] src_cnt,
  output logic [IMG_V_BITWIDTH-1:0] des_cnt
`ifdef SCALER_V_CTRL_TIMEOUT_EN
  ,
  output logic                      timeout_err
`endif
);

  localparam int unsigned W      = IMG_V_BITWIDTH;
  localparam int unsigned WAIT_W = (LUT_LATENCY > 1) ? $clog2(LUT_LATENCY) : 1;
  localparam logic [W-1:0]      KMAX      = W'(KERNEL_MAX);
  localparam logic [W-1:0]      VMAX      = W'(IMG_V_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((LUT_LATENCY > 0) ? LUT_LATENCY - 1 : 0);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_PRIME, S_STEP, S_WAIT, S_DECIDE, S_EMIT, S_FETCH, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      src_v_q, src_v_d, des_v_q, des_v_d;
  logic [W-1:0]      src_cnt_q, src_cnt_d, des_cnt_q, des_cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              pend_q, pend_d;
  logic              gap_q, gap_d;

  logic [W-1:0] src_arg, des_arg, prime_tgt, src_inc, des_inc;

  assign src_arg   = (core_arg_img_src_v > VMAX) ? VMAX : core_arg_img_src_v;
  assign des_arg   = (core_arg_img_des_v > VMAX) ? VMAX : core_arg_img_des_v;
  assign prime_tgt = (src_v_q < KMAX) ? src_v_q : KMAX;
  assign src_inc   = (src_cnt_q < src_v_q) ? src_cnt_q + W'(1) : src_cnt_q;
  assign des_inc   = (des_cnt_q < des_v_q) ? des_cnt_q + W'(1) : des_cnt_q;

`ifdef SCALER_V_CTRL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            timeout_q, timeout_d;
  assign timeout_err = timeout_q;
`endif

  always_comb begin
    state_d    = state_q;
    src_v_d    = src_v_q;
    des_v_d    = des_v_q;
    src_cnt_d  = src_cnt_q;
    des_cnt_d  = des_cnt_q;
    wait_d     = wait_q;
    pend_d     = pend_q;
    gap_d      = gap_q;
    lut_rst    = 1'b0;
    v_start    = 1'b0;
    fetch_req  = 1'b0;
    emit_req   = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          src_v_d   = src_arg;
          des_v_d   = des_arg;
          src_cnt_d = '0;
          des_cnt_d = '0;
          pend_d    = 1'b0;
          gap_d     = 1'b0;
          state_d   = S_INIT;
        end
      end
      S_INIT: begin
        lut_rst = 1'b1;
        state_d = ((src_v_q == '0) || (des_v_q == '0)) ? S_DONE : S_PRIME;
      end
      S_PRIME: begin
        // One idle cycle between consecutive prime fetches so each request drops after its ack.
        if (gap_q) begin
          gap_d = 1'b0;
        end else begin
          fetch_req = 1'b1;
          if (fetch_ack) begin
            src_cnt_d = src_inc;
            if (src_inc >= prime_tgt) state_d = S_STEP;
            else                      gap_d   = 1'b1;
          end
        end
      end
      S_STEP: begin
        v_start = 1'b1;
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q >= WAIT_LAST) state_d = S_DECIDE;
        else                     wait_d  = wait_q + WAIT_W'(1);
      end
      S_DECIDE: begin
        if (matrix_ram_read_repeat) begin
          pend_d  = 1'b0;
          state_d = S_EMIT;
        end else if (matrix_ram_read_stride) begin
          pend_d  = 1'b0;
          state_d = S_FETCH;
        end else begin
          pend_d  = 1'b1;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        emit_req = 1'b1;
        if (emit_ack) begin
          des_cnt_d = des_inc;
          pend_d    = 1'b0;
          if (des_inc == des_v_q) state_d = S_DONE;
          else if (pend_q)        state_d = S_FETCH;
          else                    state_d = S_STEP;
        end
      end
      S_FETCH: begin
        if (src_cnt_q >= src_v_q) begin
          state_d = S_STEP;
        end else begin
          fetch_req = 1'b1;
          if (fetch_ack) begin
            src_cnt_d = src_inc;
            state_d   = S_STEP;
          end
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SCALER_V_CTRL_TIMEOUT_EN
    wdog_d    = '0;
    timeout_d = 1'b0;
    if ((fetch_req && !fetch_ack) || (emit_req && !emit_ack)) begin
      if (wdog_q >= WD_W'(TIMEOUT_CYCLES - 1)) begin
        state_d   = S_IDLE;
        pend_d    = 1'b0;
        gap_d     = 1'b0;
        timeout_d = 1'b1;
      end else begin
        wdog_d = wdog_q + WD_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q   <= S_IDLE;
      src_v_q   <= '0;
      des_v_q   <= '0;
      src_cnt_q <= '0;
      des_cnt_q <= '0;
      wait_q    <= '0;
      pend_q    <= 1'b0;
      gap_q     <= 1'b0;
`ifdef SCALER_V_CTRL_TIMEOUT_EN
      wdog_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      src_v_q   <= src_v_d;
      des_v_q   <= des_v_d;
      src_cnt_q <= src_cnt_d;
      des_cnt_q <= des_cnt_d;
      wait_q    <= wait_d;
      pend_q    <= pend_d;
      gap_q     <= gap_d;
`ifdef SCALER_V_CTRL_TIMEOUT_EN
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign src_cnt = src_cnt_q;
  assign des_cnt = des_cnt_q;

endmodule

// File: tb/tb_scaler_v_ctrl.sv
// Self-checking bench for scaler_v_ctrl: LUT stub, ack responder and transaction-order reference model.
module tb_scaler_v_ctrl;

  localparam int W    = 11;
  localparam int KMAX = 4;
  localparam int LAT  = 2;
  localparam int K_NONE = 0;
  localparam int K_F    = 1;
  localparam int K_E    = 2;

  logic         core_clk = 1'b0;
  logic         core_rst_n = 1'b0;
  logic [W-1:0] core_arg_img_src_v = '0;
  logic [W-1:0] core_arg_img_des_v = '0;
  logic         frame_start = 1'b0;
  logic         lut_rst, v_start, fetch_req, emit_req, busy, frame_done;
  logic         fetch_ack = 1'b0;
  logic         emit_ack = 1'b0;
  logic         lut_rep = 1'b0;
  logic         lut_str = 1'b0;
  logic [W-1:0] src_cnt, des_cnt;

  scaler_v_ctrl #(
    .IMG_V_MAX(1080), .IMG_V_BITWIDTH(W), .KERNEL_MAX(KMAX), .LUT_LATENCY(LAT)
  ) dut (
    .core_clk(core_clk), .core_rst_n(core_rst_n),
    .core_arg_img_src_v(core_arg_img_src_v), .core_arg_img_des_v(core_arg_img_des_v),
    .frame_start(frame_start), .lut_rst(lut_rst), .v_start(v_start),
    .matrix_ram_read_stride(lut_str), .matrix_ram_read_repeat(lut_rep),
    .fetch_req(fetch_req), .fetch_ack(fetch_ack), .emit_req(emit_req), .emit_ack(emit_ack),
    .busy(busy), .frame_done(frame_done), .src_cnt(src_cnt), .des_cnt(des_cnt)
  );

  always #5 core_clk = ~core_clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // LUT stub: flags show garbage right after v_start and become valid LAT cycles later.
  bit pat_rep[256];
  bit pat_str[256];
  logic [LAT-1:0] vpipe = '0;
  logic [LAT-1:0] vpipe_n;
  int lut_idx = 0;
  assign vpipe_n = {vpipe[LAT-2:0], v_start};

  always @(posedge core_clk) begin
    if (lut_rst) begin
      lut_idx <= 0;
      vpipe   <= '0;
    end else begin
      vpipe <= vpipe_n;
      if (vpipe_n[LAT-1]) begin
        lut_rep <= pat_rep[lut_idx % 256];
        lut_str <= pat_str[lut_idx % 256];
        lut_idx <= lut_idx + 1;
      end else if (v_start) begin
        lut_rep <= 1'($urandom);
        lut_str <= 1'($urandom);
      end
    end
  end

  // Reference model: expected transaction order and final counts for one frame.
  int exp_q[$];
  int exp_src, exp_des, exp_steps;

  function automatic void build_model(input int s, input int d);
    int src = 0;
    int des = 0;
    int step = 0;
    exp_q.delete();
    if (s > 0 && d > 0) begin
      for (int i = 0; i < ((s < KMAX) ? s : KMAX); i++) begin
        exp_q.push_back(K_F);
        src++;
      end
      while (des < d && step < 4000) begin
        bit r, t;
        r = pat_rep[step % 256];
        t = pat_str[step % 256];
        step++;
        if (r || !t) begin
          exp_q.push_back(K_E);
          des++;
          if (des == d) break;
        end
        if (!r && src < s) begin
          exp_q.push_back(K_F);
          src++;
        end
      end
    end
    exp_src = src;
    exp_des = des;
    exp_steps = step;
  endfunction

  function automatic int count_kind(input int k);
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i] == k) n++;
    return n;
  endfunction

  task automatic set_pattern(input int kind);
    for (int i = 0; i < 256; i++) begin
      case (kind)
        0: begin pat_rep[i] = 1'b0;         pat_str[i] = (i % 3 != 0); end
        1: begin pat_rep[i] = (i % 3 != 2); pat_str[i] = 1'b0;         end
        2: begin pat_rep[i] = 1'b0;         pat_str[i] = 1'b0;         end
        default: begin
          pat_rep[i] = 1'($urandom);
          pat_str[i] = 1'($urandom);
        end
      endcase
    end
  endtask

  // Compare process and ack responder, both on the falling edge.
  int m_src = 0, m_des = 0, vcount = 0, done_cnt = 0;
  int cyc = 0, vcyc = 0, cur = 0, dly = 0, just_acked = 0;
  int ack_fixed = -1;
  bit pend = 0, after_step = 0, spur_en = 0;

  always @(negedge core_clk) begin
    fetch_ack = 1'b0;
    emit_ack  = 1'b0;
    cyc++;
    if (!core_rst_n) begin
      pend = 0;
      just_acked = K_NONE;
      after_step = 0;
    end else begin
      if (just_acked == K_F) chk("fetch_req_drop", fetch_req, 0);
      else if (just_acked == K_E) chk("emit_req_drop", emit_req, 0);
      just_acked = K_NONE;
      if (fetch_req || emit_req) chk("req_exclusive", fetch_req & emit_req, 0);
      if (busy) begin
        chk("src_cnt", src_cnt, m_src);
        chk("des_cnt", des_cnt, m_des);
      end
      if (v_start) begin
        vcount++;
        vcyc = cyc;
        after_step = 1;
      end
      if (frame_done) done_cnt++;
      if (!pend && (fetch_req || emit_req)) begin
        cur = fetch_req ? K_F : K_E;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got kind %0d expected none", cur);
        end else begin
          chk("req_kind", cur, exp_q.pop_front());
        end
        if (after_step) chk("decide_latency", cyc - vcyc, LAT + 2);
        after_step = 0;
        pend = 1;
        dly = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 3));
      end
      if (pend) begin
        if (cur == K_F) chk("fetch_req_hold", fetch_req, 1);
        else            chk("emit_req_hold", emit_req, 1);
        if (dly == 0) begin
          if (cur == K_F) begin fetch_ack = 1'b1; m_src++; end
          else            begin emit_ack  = 1'b1; m_des++; end
          pend = 0;
          just_acked = cur;
        end else begin
          dly--;
        end
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) fetch_ack = 1'b1;
        else                           emit_ack  = 1'b1;
      end
    end
  end

  task automatic prep(input int s, input int d, input int kind);
    set_pattern(kind);
    build_model(s, d);
    m_src = 0; m_des = 0; vcount = 0; done_cnt = 0;
    core_arg_img_src_v = W'(s);
    core_arg_img_des_v = W'(d);
  endtask

  task automatic run_frame(input int s, input int d, input int kind, input int fixed,
                           input bit extra, input int lit_f, input int lit_e);
    int n = 0;
    prep(s, d, kind);
    ack_fixed = fixed;
    if (lit_f >= 0) begin
      chk("model_fetches", count_kind(K_F), lit_f);
      chk("model_emits", count_kind(K_E), lit_e);
    end
    @(negedge core_clk) frame_start = 1'b1;
    @(negedge core_clk) frame_start = 1'b0;
    while (done_cnt == 0 && n < 4000) begin
      @(negedge core_clk);
      n++;
      frame_start = (extra && n == 15) ? 1'b1 : 1'b0;
    end
    frame_start = 1'b0;
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got no frame_done expected one within 4000 cycles (src %0d des %0d)", s, d);
      core_rst_n = 1'b0;
      @(negedge core_clk) core_rst_n = 1'b1;
    end else begin
      repeat (3) @(negedge core_clk);
      chk("frame_done_count", done_cnt, 1);
      chk("busy_after_done", busy, 0);
      chk("final_src_cnt", src_cnt, exp_src);
      chk("final_des_cnt", des_cnt, exp_des);
      chk("v_start_count", vcount, exp_steps);
      chk("pending_expected", exp_q.size(), 0);
      if (lit_f >= 0) begin
        chk("final_src_lit", src_cnt, lit_f);
        chk("final_des_lit", des_cnt, lit_e);
      end
    end
    ack_fixed = -1;
  endtask

  task automatic zero_frame(input int s, input int d);
    prep(s, d, 2);
    @(negedge core_clk) frame_start = 1'b1;
    @(negedge core_clk) frame_start = 1'b0;
    chk("zero_init_lut_busy_done", {lut_rst, busy, frame_done}, 3'b110);
    @(negedge core_clk);
    chk("zero_done_lut_busy_done", {lut_rst, busy, frame_done}, 3'b001);
    @(negedge core_clk);
    chk("zero_idle_lut_busy_done", {lut_rst, busy, frame_done}, 3'b000);
    @(negedge core_clk);
    chk("zero_v_start_count", vcount, 0);
    chk("zero_done_count", done_cnt, 1);
    chk("zero_counts", {src_cnt, des_cnt}, 0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge core_clk);
    chk("reset_outputs", {lut_rst, v_start, fetch_req, emit_req, busy, frame_done, src_cnt, des_cnt}, 0);
    core_rst_n = 1'b1;
    repeat (2) @(negedge core_clk);
    chk("idle_outputs", {lut_rst, v_start, fetch_req, emit_req, busy, frame_done, src_cnt, des_cnt}, 0);

    run_frame(12, 4, 0, -1, 1'b0, 12, 4);
    run_frame(4, 12, 1, -1, 1'b0, 4, 12);
    run_frame(8, 8, 2, -1, 1'b0, 8, 8);
    zero_frame(0, 5);
    zero_frame(5, 0);
    zero_frame(0, 0);

    run_frame(4, 3, 1, 9, 1'b1, 4, 3);

    // Asynchronous reset while a steady-state fetch is outstanding.
    prep(12, 4, 0);
    ack_fixed = 9;
    @(negedge core_clk) frame_start = 1'b1;
    @(negedge core_clk) frame_start = 1'b0;
    n = 0;
    while (!(fetch_req && vcount >= 1) && n < 2000) begin
      @(negedge core_clk);
      n++;
    end
    chk("reached_fetch", fetch_req && vcount >= 1, 1);
    #2 core_rst_n = 1'b0;
    #1 chk("async_reset_outputs", {fetch_req, emit_req, busy, frame_done, src_cnt, des_cnt}, 0);
    @(negedge core_clk);
    #2 core_rst_n = 1'b1;
    repeat (3) @(negedge core_clk);
    chk("no_done_after_reset", done_cnt, 0);
    chk("idle_after_reset", busy, 0);
    ack_fixed = -1;
    run_frame(12, 4, 0, -1, 1'b0, 12, 4);

    spur_en = 1;
    for (int i = 0; i < 20; i++)
      run_frame(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)), 3, -1, 1'b0, -1, -1);
    spur_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
